// File: rtl/m6502_db_pkg.sv
// Shared definitions for the 6502 single-step controller.
// Holds the controller state encoding and the default widths / debounce
// length used by m6502_step_ctrl and sw_debounce.
package m6502_db_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int STEP_W_DEF     = 8;
  localparam int DEB_CYCLES_DEF = 1000;

  // RUN : CPU free-running (RDY=1)
  // HALT: CPU held (RDY=0)
  // STEP: one released bus cycle
  // INST: released until a number of instruction fetches have been counted
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2,
    ST_INST = 2'd3
  } step_state_t;

endpackage

// File: rtl/m6502_step_ctrl_sw_debounce.sv
// sw_debounce: front end for one raw front-panel switch.
// Ports:
//   clk   in  clock (PHI2)
//   rst_n in  asynchronous active-low reset
//   raw   in  raw switch level (idle = 1)
//   deb   out debounced level, resets to 1
//   press out one-cycle pulse on the debounced 1->0 edge
// The raw level passes a 2-FF synchroniser; the debounced level follows it
// only after the two have disagreed for DEB_CYCLES consecutive cycles.
module sw_debounce
  import m6502_db_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             deb_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      deb_reg   <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg != deb_reg) begin
        // This edge is the DEB_CYCLES-th consecutive disagreement.
        if (cnt_reg == CNT_LAST) begin
          deb_reg   <= sync2_reg;
          cnt_reg   <= '0;
          press_reg <= ~sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign deb   = deb_reg;
  assign press = press_reg;

endmodule

// File: rtl/m6502_step_ctrl.sv
// m6502_step_ctrl: run / halt / single-cycle / N-instruction controller that
// drives the 6502 RDY line, with an address breakpoint.
// Ports:
//   PHI2        in  clock; RESET_N in async active-low reset
//   RUN_SW      in  raw run(1)/halt(0) switch
//   SC_N, SI_N  in  raw single-cycle / single-instruction buttons (low=pressed)
//   SYNC_N, W_N in  inverted SYNC and R/W from the CPU
//   ADDR        in  CPU address bus
//   BP_EN, BP_ADDR in breakpoint enable / address
//   STEP_COUNT  in  instructions per SI press (0 behaves as 1)
//   RDY, HALTED out registered CPU ready / halted flag
//   LED_SYN_N, LED_WR_N, LED_BRK_N out active-low status LEDs
module m6502_step_ctrl
  import m6502_db_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STEP_W     = STEP_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              PHI2,
  input  logic              RESET_N,
  input  logic              RUN_SW,
  input  logic              SC_N,
  input  logic              SI_N,
  input  logic              SYNC_N,
  input  logic              W_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              BP_EN,
  input  logic [ADDR_W-1:0] BP_ADDR,
  input  logic [STEP_W-1:0] STEP_COUNT,
  output logic              RDY,
  output logic              HALTED,
  output logic              LED_SYN_N,
  output logic              LED_WR_N,
  output logic              LED_BRK_N
);

  // Index 0 = RUN_SW, 1 = SC_N, 2 = SI_N
  logic [2:0] raw_vec;
  logic [2:0] deb_vec;
  logic [2:0] press_vec;
  logic [2:0] unused_bits;

  assign raw_vec = {SI_N, SC_N, RUN_SW};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      sw_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk  (PHI2),
        .rst_n(RESET_N),
        .raw  (raw_vec[gi]),
        .deb  (deb_vec[gi]),
        .press(press_vec[gi])
      );
    end
  endgenerate

  // Debounced button levels and the run-switch edge are not needed here.
  assign unused_bits = {deb_vec[2:1], press_vec[0]};

  logic              run_db;
  logic              sc_press;
  logic              si_press;
  logic              sync;
  logic              bp_hit;
  logic [STEP_W-1:0] step_load;

  assign run_db    = deb_vec[0];
  assign sc_press  = press_vec[1];
  assign si_press  = press_vec[2];
  assign sync      = ~SYNC_N;
  assign bp_hit    = BP_EN & sync & (ADDR == BP_ADDR);
  assign step_load = (STEP_COUNT == '0) ? STEP_W'(1) : STEP_COUNT;

  step_state_t       state_reg;
  logic              rdy_reg;
  logic              halted_reg;
  logic              brk_reg;
  logic              first_reg;   // first cycle after leaving HALT
  logic [STEP_W-1:0] cnt_reg;
  logic              led_syn_reg;
  logic              led_wr_reg;
  logic              led_brk_reg;

  always_ff @(posedge PHI2 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= ST_RUN;
      rdy_reg     <= 1'b1;
      halted_reg  <= 1'b0;
      brk_reg     <= 1'b0;
      first_reg   <= 1'b0;
      cnt_reg     <= '0;
      led_syn_reg <= 1'b1;
      led_wr_reg  <= 1'b1;
      led_brk_reg <= 1'b1;
    end else begin
      first_reg  <= 1'b0;
      led_wr_reg <= W_N;
      case (state_reg)
        ST_RUN: begin
          // The first cycle after HALT is skipped so a CPU parked on the
          // breakpoint address can move off it.
          if (!first_reg && sync && (!run_db || bp_hit)) begin
            state_reg   <= ST_HALT;
            rdy_reg     <= 1'b0;
            halted_reg  <= 1'b1;
            brk_reg     <= bp_hit;
            led_brk_reg <= ~bp_hit;
            led_syn_reg <= 1'b0;
          end
        end
        ST_HALT: begin
          led_syn_reg <= ~sync;
          // Any exit clears the breakpoint flag and arms the skip cycle.
          if (run_db || sc_press || si_press) begin
            rdy_reg     <= 1'b1;
            halted_reg  <= 1'b0;
            brk_reg     <= 1'b0;
            first_reg   <= 1'b1;
            led_brk_reg <= 1'b1;
            led_syn_reg <= 1'b1;
          end
          // Priority: run switch, then SC over SI on a shared edge.
          if (run_db) begin
            state_reg <= ST_RUN;
          end else if (sc_press) begin
            state_reg <= ST_STEP;
          end else if (si_press) begin
            state_reg <= ST_INST;
            cnt_reg   <= step_load;
          end
        end
        ST_STEP: begin
          if (run_db) begin
            state_reg <= ST_RUN;
          end else begin
            state_reg   <= ST_HALT;
            rdy_reg     <= 1'b0;
            halted_reg  <= 1'b1;
            led_syn_reg <= ~sync;
          end
        end
        ST_INST: begin
          if (run_db) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
          end else if (!first_reg && sync) begin
            if (cnt_reg == STEP_W'(1) || bp_hit) begin
              state_reg   <= ST_HALT;
              rdy_reg     <= 1'b0;
              halted_reg  <= 1'b1;
              cnt_reg     <= '0;
              brk_reg     <= bp_hit;
              led_brk_reg <= ~bp_hit;
              led_syn_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        default: begin
          state_reg  <= ST_RUN;
          rdy_reg    <= 1'b1;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  assign RDY       = rdy_reg;
  assign HALTED    = halted_reg;
  assign LED_SYN_N = led_syn_reg;
  assign LED_WR_N  = led_wr_reg;
  assign LED_BRK_N = led_brk_reg;

endmodule

// File: tb/tb_m6502_step_ctrl.sv
// Self-checking bench for m6502_step_ctrl with DEB_CYCLES=4.
// Expected values are queued as each stimulus step is driven and popped
// when the corresponding DUT output is sampled (1 time unit after PHI2 rises).
module tb_m6502_step_ctrl;

  logic        phi2 = 1'b0;
  logic        rst_n;
  logic        run_sw;
  logic        sc_n;
  logic        si_n;
  logic        sync_n;
  logic        w_n;
  logic [15:0] addr;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [7:0]  step_count;
  logic        rdy;
  logic        halted;
  logic        led_syn_n;
  logic        led_wr_n;
  logic        led_brk_n;

  m6502_step_ctrl #(
    .ADDR_W(16),
    .STEP_W(8),
    .DEB_CYCLES(4)
  ) dut (
    .PHI2      (phi2),
    .RESET_N   (rst_n),
    .RUN_SW    (run_sw),
    .SC_N      (sc_n),
    .SI_N      (si_n),
    .SYNC_N    (sync_n),
    .W_N       (w_n),
    .ADDR      (addr),
    .BP_EN     (bp_en),
    .BP_ADDR   (bp_addr),
    .STEP_COUNT(step_count),
    .RDY       (rdy),
    .HALTED    (halted),
    .LED_SYN_N (led_syn_n),
    .LED_WR_N  (led_wr_n),
    .LED_BRK_N (led_brk_n)
  );

  always #5 phi2 = ~phi2;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, want, $time);
    end else begin
      $display("ok   %s = %0d (t=%0t)", tag, obs, $time);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // One PHI2 cycle with the given sync level presented at the edge.
  task automatic cyc(input logic s);
    sync_n = ~s;
    @(posedge phi2);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic wait_rdy(input logic target, input logic s, input int max_cyc);
    int n;
    n = 0;
    while (rdy !== target && n < max_cyc) begin
      cyc(s);
      n++;
    end
  endtask

  // SI press, then sync every 4th cycle; counts syncs seen while released.
  task automatic si_run(input logic [7:0] cnt_in, input int exp_syncs, input string tag);
    int k;
    int syncs;
    logic s;
    step_count = cnt_in;
    si_n = 1'b0;
    wait_rdy(1'b1, 1'b0, 12);
    push_exp({tag, "_enter_rdy"}, 1);
    pop_check(rdy);
    si_n = 1'b1;
    k = 0;
    syncs = 0;
    while (rdy === 1'b1 && k < 60) begin
      k++;
      s = (k % 4 == 0);
      if (s) syncs++;
      cyc(s);
    end
    push_exp({tag, "_syncs"}, exp_syncs);
    pop_check(syncs);
    push_exp({tag, "_halted"}, 1);
    pop_check(halted);
    settle(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   hi;
    logic s;
    logic last_s;

    rst_n      = 1'b0;
    run_sw     = 1'b0;
    sc_n       = 1'b1;
    si_n       = 1'b1;
    sync_n     = 1'b1;
    w_n        = 1'b1;
    addr       = 16'h0000;
    bp_en      = 1'b0;
    bp_addr    = 16'hC000;
    step_count = 8'd1;

    // Reset state
    #23;
    push_exp("reset_rdy", 1);       pop_check(rdy);
    push_exp("reset_halted", 0);    pop_check(halted);
    push_exp("reset_led_syn", 1);   pop_check(led_syn_n);
    push_exp("reset_led_wr", 1);    pop_check(led_wr_n);
    push_exp("reset_led_brk", 1);   pop_check(led_brk_n);

    // Release with RUN_SW=0: synchroniser (2) + debounce (4) edges, then
    // the first sync edge (every 3rd cycle) is edge 9.
    @(posedge phi2);
    #1;
    rst_n = 1'b1;
    n = 0;
    last_s = 1'b0;
    while (rdy === 1'b1 && n < 40) begin
      n++;
      s = (n % 3 == 0);
      cyc(s);
      last_s = s;
    end
    push_exp("halt_edge", 9);        pop_check(n);
    push_exp("halt_on_sync", 1);     pop_check(last_s);
    push_exp("halt_halted", 1);      pop_check(halted);
    push_exp("halt_led_syn", 0);     pop_check(led_syn_n);
    push_exp("halt_led_brk", 1);     pop_check(led_brk_n);
    cyc(1'b0);
    push_exp("halt_led_syn_nosync", 1); pop_check(led_syn_n);

    // Write LED follows sampled W_N
    w_n = 1'b0;
    cyc(1'b0);
    push_exp("led_wr_low", 0);  pop_check(led_wr_n);
    w_n = 1'b1;
    cyc(1'b0);
    push_exp("led_wr_high", 1); pop_check(led_wr_n);

    // Single cycle: held press gives exactly one RDY cycle
    hi = 0;
    sc_n = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1'b0); if (rdy === 1'b1) hi++; end
    sc_n = 1'b1;
    for (int i = 0; i < 10; i++) begin cyc(1'b0); if (rdy === 1'b1) hi++; end
    push_exp("sc_rdy_cycles", 1);  pop_check(hi);
    push_exp("sc_back_halted", 1); pop_check(halted);

    // Bouncing button of 1-cycle pulses: no step
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      sc_n = (i % 2 == 1);
      cyc(1'b0);
      if (rdy === 1'b1) hi++;
    end
    sc_n = 1'b1;
    for (int i = 0; i < 8; i++) begin cyc(1'b0); if (rdy === 1'b1) hi++; end
    push_exp("bounce_rdy_cycles", 0); pop_check(hi);

    // N-instruction steps
    si_run(8'd3, 3, "si3");
    si_run(8'd0, 1, "si0");

    // Breakpoint while running (RUN_SW=1 resumes on the next edge)
    run_sw = 1'b1;
    wait_rdy(1'b1, 1'b0, 20);
    push_exp("resume_rdy", 1); pop_check(rdy);
    cyc(1'b0);
    bp_en = 1'b1;
    addr  = 16'hC000;
    cyc(1'b1);
    push_exp("bp_rdy", 0);      pop_check(rdy);
    push_exp("bp_halted", 1);   pop_check(halted);
    push_exp("bp_led_brk", 0);  pop_check(led_brk_n);
    cyc(1'b0);
    push_exp("bp_exit_rdy", 1);     pop_check(rdy);
    push_exp("bp_exit_led_brk", 1); pop_check(led_brk_n);

    // Halt again on breakpoint with RUN_SW=0, then SI with sync held high
    run_sw = 1'b0;
    settle(8);
    push_exp("run_no_sync_rdy", 1); pop_check(rdy);
    cyc(1'b1);
    push_exp("bp2_halted", 1);  pop_check(halted);
    push_exp("bp2_led_brk", 0); pop_check(led_brk_n);
    step_count = 8'd1;
    si_n = 1'b0;
    wait_rdy(1'b1, 1'b1, 12);
    push_exp("bp_si_rdy", 1);     pop_check(rdy);
    push_exp("bp_si_led_brk", 1); pop_check(led_brk_n);
    cyc(1'b1);
    push_exp("bp_first_ignored", 1); pop_check(rdy);
    cyc(1'b1);
    push_exp("bp_si_rehalt", 0);     pop_check(rdy);
    push_exp("bp_si_led_brk2", 0);   pop_check(led_brk_n);
    si_n = 1'b1;
    bp_en = 1'b0;
    settle(8);

    // Same-edge SC and SI: STEP wins (INST would hold RDY with no sync)
    sc_n = 1'b0;
    si_n = 1'b0;
    wait_rdy(1'b1, 1'b0, 12);
    push_exp("dual_rdy", 1); pop_check(rdy);
    cyc(1'b0);
    push_exp("dual_sc_wins", 0); pop_check(rdy);
    sc_n = 1'b1;
    si_n = 1'b1;
    settle(8);

    // Reset during INST with cnt=2
    step_count = 8'd2;
    si_n = 1'b0;
    wait_rdy(1'b1, 1'b0, 12);
    push_exp("inst2_rdy", 1); pop_check(rdy);
    cyc(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_rst_rdy", 1);     pop_check(rdy);
    push_exp("async_rst_halted", 0);  pop_check(halted);
    push_exp("async_rst_led_brk", 1); pop_check(led_brk_n);
    si_n = 1'b1;
    run_sw = 1'b1;
    @(posedge phi2);
    #1;
    rst_n = 1'b1;
    hi = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(i % 3 == 0);
      if (rdy !== 1'b1) hi++;
    end
    push_exp("post_rst_run_low_cycles", 0); pop_check(hi);

    if (exp_q.size() != 0) check_val("scoreboard_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m6502_step_ctrl.md
M6502_STEP_CTRL -- requirements
Module: m6502_step_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, CPU address bus width.
REQ-002 Parameter STEP_W, default 8, instruction step-count width.
REQ-003 Parameter DEB_CYCLES, default 1000, PHI2 cycles an input must hold stable to be accepted; range 2 to 65535.
REQ-004 PHI2  in  1  sole clock (6502 PHI2); all state SHALL update on its rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous, active-low.
REQ-006 RUN_SW  in  1  raw run/halt toggle: 1=run, 0=halt.
REQ-007 SC_N  in  1  raw single-cycle button, low=pressed.
REQ-008 SI_N  in  1  raw single/N-instruction button, low=pressed.
REQ-009 SYNC_N  in  1  6502 SYNC, inverted.
REQ-010 W_N  in  1  6502 R/W: 1=read, 0=write.
REQ-011 ADDR  in  ADDR_W  CPU address bus.
REQ-012 BP_EN  in  1  breakpoint enable.
REQ-013 BP_ADDR  in  ADDR_W  breakpoint address.
REQ-014 STEP_COUNT  in  STEP_W  instructions per SI press; 0 is treated as 1.
REQ-015 RDY  out  1  6502 RDY, registered.
REQ-016 HALTED  out  1  high in state HALT.
REQ-017 LED_SYN_N  out  1  low when HALTED and sampled SYNC=1.
REQ-018 LED_WR_N  out  1  low when sampled W_N=0.
REQ-019 LED_BRK_N  out  1  low while halted by breakpoint.

Function
REQ-020 RUN_SW, SC_N and SI_N SHALL each pass a 2-FF synchroniser, then a debouncer whose output changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles.
REQ-021 A press event SHALL be a one-cycle pulse on the debounced 1->0 edge of SC_N or SI_N.
REQ-022 SYNC_N, W_N, ADDR, BP_EN and BP_ADDR SHALL be sampled once per edge. sync = !SYNC_N. bp_hit = BP_EN & sync & (ADDR==BP_ADDR).
REQ-023 States: RUN, HALT, STEP, INST. RDY SHALL be 1 in RUN, STEP and INST, and 0 in HALT. The RDY register SHALL take its next-state value on the same edge as the state transition.
REQ-024 RUN->HALT on the edge where sync=1 and (debounced RUN_SW=0 or bp_hit). bp_hit SHALL set brk_flag.
REQ-025 HALT->RUN when debounced RUN_SW=1.
REQ-026 HALT->STEP on an SC press.
REQ-027 HALT->INST on an SI press, loading cnt = max(STEP_COUNT,1).
REQ-028 If SC and SI presses occur on the same edge, SC SHALL win.
REQ-029 STEP SHALL last exactly one cycle, then return to HALT, or go to RUN if debounced RUN_SW=1.
REQ-030 In INST, cnt SHALL decrement on each edge with sync=1, excluding the first cycle after leaving HALT.
REQ-031 INST->HALT on a counted sync edge where cnt==1 or bp_hit; bp_hit sets brk_flag.
REQ-032 INST->RUN if debounced RUN_SW=1, checked before the cnt and bp_hit rules.
REQ-033 The first cycle after leaving HALT SHALL ignore sync and bp_hit, so the CPU leaves the breakpoint address.
REQ-034 Press events SHALL be ignored outside HALT.
REQ-035 Any exit from HALT SHALL clear brk_flag.
REQ-036 LED_BRK_N = !(HALTED & brk_flag).

Reset
REQ-037 RESET_N low SHALL asynchronously force:
  - state=RUN, RDY=1, HALTED=0, cnt=0, brk_flag=0
  - all LED outputs 1
  - debounced RUN_SW=1, SC_N=1, SI_N=1; debounce counters 0; synchronisers 1
REQ-038 Reset asserted mid-STEP or mid-INST SHALL abandon the operation with no residual count.
REQ-039 After reset release, the block SHALL halt at the first sync if debounced RUN_SW=0.

Structure
REQ-040 Package m6502_db_pkg SHALL hold the state encoding type and the defaults for ADDR_W, STEP_W and DEB_CYCLES.
REQ-041 Sub-module sw_debounce (synchroniser, counter, press pulse, parameter DEB_CYCLES) SHALL be instantiated three times.

Verification (DEB_CYCLES=4, STEP_W=8)
REQ-042 Reset; RUN_SW=0 held; sync every 3rd cycle -> RDY drops on the first sync edge once debounce completes (>=6 edges); HALTED=1.
REQ-043 HALT; SC_N low for 10 cycles -> RDY=1 for exactly 1 cycle then 0; a bouncing SC_N of 1-cycle pulses -> no step.
REQ-044 HALT; STEP_COUNT=3; SI press; sync every 4 cycles -> RDY high through 3 counted syncs, halts on the 3rd; STEP_COUNT=0 -> halts at the 1st.
REQ-045 RUN; BP_EN=1, BP_ADDR=16'hC000; sync with ADDR=16'hC000 -> HALT, LED_BRK_N=0. SI press -> first cycle ignores the hit; LED_BRK_N=1.
REQ-046 Same-edge SC and SI presses -> STEP taken. RESET_N low during INST with cnt=2 -> state RUN, RDY=1 asynchronously.
